alu_seq: RTL

Sequential, parametrised successor to the combinational ALU. It accepts one operation per valid/ready handshake and executes logic, add and subtract in a single cycle. Shifts run iteratively at one bit per cycle, and multiply uses W-cycle shift-add. Results and all four flags (c_out, v, n, z) are registered and held under output backpressure. It sits between the operand/issue logic and the writeback stage.

---
 rtl/alu_ops_pkg.sv | 26 ++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_adder.sv | 17 +
 rtl/alu_gate.sv | 10 +
 rtl/alu_iter_unit.sv | 66 ++++++
 rtl/alu_seq.sv | 87 ++++++++
 6 files changed

// File: rtl/alu_ops_pkg.sv
// alu_ops: shared opcode encoding, FSM state codes and opcode classifiers for alu_seq.
package alu_ops;
    typedef enum logic [3:0] {
        OP_LL  = 4'd0,
        OP_LR  = 4'd1,
        OP_AL  = 4'd2,
        OP_AR  = 4'd3,
        OP_NOT = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_ADD = 4'd8,
        OP_SUB = 4'd9,
        OP_MUL = 4'd10
    } opcode_t;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_BUSY = 2'd1;
    localparam state_t S_DONE = 2'd2;
    function automatic logic is_illegal(input logic [3:0] op);
        return op > 4'd10;
    endfunction
    function automatic logic is_shift(input logic [3:0] op);
        return op < 4'd4;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result handshake bundle between issue logic (master) and alu_seq (slave).
// Issue side: in_valid, in_ready, opcode, a, b, c_in. Result side: out_valid, out_ready, y, c_out, v, n, z, err.
interface alu_seq_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         c_out;
    logic         v;
    logic         n;
    logic         z;
    logic         err;
    modport master (
        output in_valid, opcode, a, b, c_in, out_ready,
        input  in_ready, out_valid, y, c_out, v, n, z, err
    );
    modport slave (
        input  in_valid, opcode, a, b, c_in, out_ready,
        output in_ready, out_valid, y, c_out, v, n, z, err
    );
endinterface

// File: rtl/alu_adder.sv
// alu_adder: combinational add/subtract with carry in, carry out and signed overflow.
// Ports: a, b, c_in, sub (1 = a + ~b + c_in); y, c_out, v.
module alu_adder #(parameter int W = 8) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         c_out,
    output logic         v
);
    logic [W-1:0] bb;
    assign bb = sub ? ~b : b;
    assign {c_out, y} = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c_in};
    // Overflow is judged against the effective second operand, so SUB reuses the ADD rule.
    assign v = (a[W-1] == bb[W-1]) && (y[W-1] != a[W-1]);
endmodule

// File: rtl/alu_gate.sv
// alu_gate: combinational NOT/AND/OR/XOR selected by the low two opcode bits.
// Ports: sel (opcode[1:0]), a, b operands; y result.
module alu_gate #(parameter int W = 8) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel == 2'd0 ? ~a : sel == 2'd1 ? a & b : sel == 2'd2 ? a | b : a ^ b;
endmodule

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: iterative datapath for shifts (one bit per cycle) and shift-add multiply.
// Ports: clk, rst; start loads op/a/b/k; done flags the final step; y, c_out, v give the post-step result.
module alu_iter_unit import alu_ops::*; #(
    parameter  int W  = 8,
    localparam int SW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [SW-1:0] k,
    output logic          done,
    output logic [W-1:0]  y,
    output logic          c_out,
    output logic          v
);
    logic [3:0]     op_r;
    logic [SW-1:0]  cnt;
    logic [W-1:0]   sh, sh_nx, mplier;
    logic [2*W-1:0] acc, acc_nx, mcand;
    logic           c_r, c_nx, v_r, v_nx, left, mul, hi;
    assign left   = op_r == OP_LL || op_r == OP_AL;
    assign mul    = op_r == OP_MUL;
    assign sh_nx  = left ? sh << 1 : {op_r == OP_AR && sh[W-1], sh[W-1:1]};
    assign c_nx   = left ? sh[W-1] : sh[0];
    // AL overflow is sticky: any step that flips the sign bit sets it.
    assign v_nx   = v_r | (op_r == OP_AL && sh[W-1] != sh[W-2]);
    assign acc_nx = acc + (mplier[0] ? mcand : '0);
    assign hi     = |acc_nx[2*W-1:W];
    // Outputs present the value after the current step so the top can register it on the final edge.
    assign done   = cnt == SW'(1);
    assign y      = mul ? acc_nx[W-1:0] : sh_nx;
    assign c_out  = mul ? hi : c_nx;
    assign v      = mul ? hi : v_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= '0;
            cnt    <= '0;
            sh     <= '0;
            mplier <= '0;
            acc    <= '0;
            mcand  <= '0;
            c_r    <= 1'b0;
            v_r    <= 1'b0;
        end else if (start) begin
            op_r   <= op;
            cnt    <= op == OP_MUL ? SW'(W) : k;
            sh     <= a;
            mplier <= b;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            c_r    <= 1'b0;
            v_r    <= 1'b0;
        end else if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            sh     <= sh_nx;
            c_r    <= c_nx;
            v_r    <= v_nx;
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready issue, single-cycle logic/add/sub and iterative shift/multiply.
// Ports: clk, rst (async, active-high); bus (alu_seq_if.slave) carries the issue and result handshakes.
module alu_seq import alu_ops::*; #(
    parameter  int W  = 8,
    localparam int SW = $clog2(W) + 1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam logic [W:0] W_EXT = (W+1)'(W);
    state_t        state, state_nx;
    logic          accept, shift, illegal, multi, it_done, it_c, it_v;
    logic          add_c, add_v, one_c, one_v, c_r, v_r, err_r;
    logic [SW-1:0] k;
    logic [W-1:0]  gate_y, add_y, one_y, it_y, y_r;
    assign k       = {1'b0, bus.b} >= W_EXT ? SW'(W) : SW'(bus.b);
    assign shift   = is_shift(bus.opcode);
    assign illegal = is_illegal(bus.opcode);
    assign multi   = (shift && k != '0) || bus.opcode == OP_MUL;
    assign bus.in_ready = state == S_IDLE || (state == S_DONE && bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready;
    alu_gate #(.W(W)) u_gate (
        .sel (bus.opcode[1:0]),
        .a   (bus.a),
        .b   (bus.b),
        .y   (gate_y)
    );
    alu_adder #(.W(W)) u_adder (
        .a     (bus.a),
        .b     (bus.b),
        .c_in  (bus.c_in),
        .sub   (bus.opcode == OP_SUB),
        .y     (add_y),
        .c_out (add_c),
        .v     (add_v)
    );
    alu_iter_unit #(.W(W)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && multi),
        .op    (bus.opcode),
        .a     (bus.a),
        .b     (bus.b),
        .k     (k),
        .done  (it_done),
        .y     (it_y),
        .c_out (it_c),
        .v     (it_v)
    );
    // Single-cycle result; a zero-length shift passes a through. Opcodes 8/9 are the only single-cycle ops with bit 3 set.
    assign one_y = illegal ? '0 : shift ? bus.a : bus.opcode[3] ? add_y : gate_y;
    assign one_c = !illegal && bus.opcode[3] && add_c;
    assign one_v = !illegal && bus.opcode[3] && add_v;
    assign state_nx = accept ? (multi ? S_BUSY : S_DONE)
                    : state == S_BUSY ? (it_done ? S_DONE : S_BUSY)
                    : state == S_DONE && bus.out_ready ? S_IDLE : state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            y_r   <= '0;
            c_r   <= 1'b0;
            v_r   <= 1'b0;
            err_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept && !multi) begin
                y_r   <= one_y;
                c_r   <= one_c;
                v_r   <= one_v;
                err_r <= illegal;
            end else if (state == S_BUSY && it_done) begin
                y_r   <= it_y;
                c_r   <= it_c;
                v_r   <= it_v;
                err_r <= 1'b0;
            end
        end
    end
    assign bus.out_valid = state == S_DONE;
    assign bus.y         = y_r;
    assign bus.c_out     = c_r;
    assign bus.v         = v_r;
    assign bus.n         = y_r[W-1];
    assign bus.z         = y_r == '0;
    assign bus.err       = err_r;
endmodule
